instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction-fetch (IF) stage of the pipelined MIPS core. It sits directly upstream of the instruction memory and drives its word-aligned byte address. It captures the returned instruction into the IF/ID pipeline register. It handles stall, branch/jump redirect with flush, and end-of-program detection.

Parameters:
IMEM_WORDS, 21, number of valid instruction words; word indices >= IMEM_WORDS are out of range.
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).

Ports:
clk  input  1  pipeline clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
stall  input  1  hazard-unit hold; freezes PC and IF/ID.
jump_req  input  1  J-type jump resolved in ID this cycle.
jump_index  input  26  instr[25:0] of the jump.
branch_req  input  1  taken branch resolved in ID this cycle.
branch_base  input  32  PC+4 of the branch instruction.
branch_imm  input  16  branch offset, in words, signed.
imem_instr  input  32  instruction word returned combinationally by instruction memory.
imem_addr  output  32  byte address to instruction memory (= PC).
if_id_instr  output  32  registered instruction for ID.
if_id_pc4  output  32  registered PC+4 of that instruction.
if_id_valid  output  1  1 = if_id_instr is a real fetched instruction.
halted  output  1  PC is out of range; fetch is suspended.
fetch_count  output  32  number of valid instructions delivered to IF/ID.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, if_id_instr=32'h0 (NOP), if_id_pc4=0, if_id_valid=0, fetch_count=0.
- halted is combinational: (pc[31:2] >= IMEM_WORDS). After reset it is 0 for the default parameters.
- imem_addr = pc, combinational. Memory read latency is zero. The instruction is captured into IF/ID on the same edge that advances the PC.
- pc4 = pc + 32'd4, 32-bit wrap-around; no carry-out.
- Jump target = {if_id_pc4[31:28], jump_index, 2'b00}.
- Branch target = branch_base + ({{14{branch_imm[15]}}, branch_imm, 2'b00}), 32-bit wrap.
- Next-PC priority per edge, highest first:
  1) stall: pc holds. IF/ID holds. fetch_count holds. jump_req and branch_req are ignored; the requester re-asserts them after the stall.
  2) jump_req: pc <= jump target. IF/ID flushed: instr=0, pc4=0, valid=0.
  3) branch_req: pc <= branch target. Same flush as a jump.
  4) halted: pc holds. IF/ID gets a bubble (instr=0, valid=0). fetch_count holds.
  5) otherwise: pc <= pc4. if_id_instr <= imem_instr, if_id_pc4 <= pc4, if_id_valid <= 1, fetch_count <= fetch_count+1.
- jump_req and branch_req asserted together: jump wins.
- A redirect while halted is accepted. halted then re-evaluates from the new pc, so fetch resumes if the target is in range.
- Targets are always word aligned by construction.
- rst asserted mid-operation forces all reset values immediately, independent of clk. Fetch restarts at RESET_PC on the first edge after release.
- fetch_count wraps at 2^32.

Decomposition:
- Shared package mips_pkg holds: NOP_INSTR (32'h0), WORD_BYTES (4), and the default RESET_PC. These are reused by the decode, hazard and writeback stages.
- One natural sub-module: if_id_reg. It owns the IF/ID flops with hold, flush and load controls, plus their async reset.
- instr_fetch_unit keeps the PC register, next-PC mux, target adders, halt compare and fetch_count.

Test Plan:
1. Sequential fetch: release rst with the program loaded (mem[0]=32'h8C10_0000) -> imem_addr 0, 4, 8 on successive cycles. After the first edge: if_id_instr=32'h8C10_0000, if_id_pc4=4, if_id_valid=1, fetch_count=1.
2. Stall: hold stall=1 for 2 cycles when pc=12 -> imem_addr stays 12, IF/ID unchanged, fetch_count unchanged. Release -> pc=16 next edge.
3. Taken branch: branch_req=1, branch_base=32'h20, branch_imm=16'h0001 -> pc=32'h24, if_id_valid=0, if_id_instr=0. Repeat with branch_imm=16'hFFFE -> pc=32'h18.
4. Jump: if_id_pc4=32'h24, jump_req=1, jump_index=13 -> pc=32'h34, IF/ID flushed. Jump and branch asserted together -> jump target taken. Stall asserted with jump -> pc holds.
5. End of program: free-run from 0 with no redirects -> at pc=84, halted=1 and pc holds at 84. if_id_valid=0 on every subsequent edge, fetch_count stays 21. Then a jump with jump_index=3 -> pc=12, halted=0.
6. Async reset mid-run: assert rst between clock edges at pc=40 -> pc=0, if_id_valid=0 and fetch_count=0 before the next edge. Sequential fetch resumes after release.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: constants, next-PC select encoding and offset helper shared by the pipeline stages.
package mips_pkg;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES   = 32'd4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_JUMP,
      SEL_BRANCH,
      SEL_HALT,
      SEL_SEQ
   } npc_sel_e;
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold, flush, bubble and load controls.
module if_id_reg
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        flush,
   input  logic        bubble,
   input  logic        load,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc4_in,
   output logic [31:0] instr,
   output logic [31:0] pc4,
   output logic        valid
);
   // a bubble keeps pc4 so a later jump still sees the last fetched region
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         instr <= NOP_INSTR;
         pc4   <= '0;
         valid <= 1'b0;
      end else if (hold) begin
         instr <= instr;
      end else if (flush) begin
         instr <= NOP_INSTR;
         pc4   <= '0;
         valid <= 1'b0;
      end else if (bubble) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (load) begin
         instr <= instr_in;
         pc4   <= pc4_in;
         valid <= 1'b1;
      end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, next-PC selection, redirect targets, halt detection and fetch count.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter int          IMEM_WORDS = 21,
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        jump_req,
   input  logic [25:0] jump_index,
   input  logic        branch_req,
   input  logic [31:0] branch_base,
   input  logic [15:0] branch_imm,
   input  logic [31:0] imem_instr,
   output logic [31:0] imem_addr,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        halted,
   output logic [31:0] fetch_count
);
   logic [31:0] pc, pc4, pc_next, jump_tgt, branch_tgt;
   npc_sel_e    sel;
   assign imem_addr  = pc;
   assign pc4        = pc + WORD_BYTES;
   assign halted     = pc[31:2] >= 30'(IMEM_WORDS);
   assign jump_tgt   = {if_id_pc4[31:28], jump_index, 2'b00};
   assign branch_tgt = branch_base + branch_offset(branch_imm);
   always_comb
      sel = stall ? SEL_HOLD : jump_req ? SEL_JUMP : branch_req ? SEL_BRANCH :
            halted ? SEL_HALT : SEL_SEQ;
   always_comb
      pc_next = sel == SEL_JUMP ? jump_tgt : sel == SEL_BRANCH ? branch_tgt :
                sel == SEL_SEQ ? pc4 : pc;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pc          <= RESET_PC;
         fetch_count <= '0;
      end else begin
         pc          <= pc_next;
         fetch_count <= fetch_count + {31'd0, sel == SEL_SEQ};
      end
   if_id_reg u_if_id (
      .clk      (clk),
      .rst      (rst),
      .hold     (sel == SEL_HOLD),
      .flush    (sel == SEL_JUMP || sel == SEL_BRANCH),
      .bubble   (sel == SEL_HALT),
      .load     (sel == SEL_SEQ),
      .instr_in (imem_instr),
      .pc4_in   (pc4),
      .instr    (if_id_instr),
      .pc4      (if_id_pc4),
      .valid    (if_id_valid)
   );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of sequential fetch, stall, redirects, halt and async reset.
module tb_instr_fetch_unit;
   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, jump_req = 1'b0, branch_req = 1'b0;
   logic [25:0] jump_index = '0;
   logic [31:0] branch_base = '0;
   logic [15:0] branch_imm = '0;
   logic [31:0] imem_instr, imem_addr, if_id_instr, if_id_pc4, fetch_count;
   logic        if_id_valid, halted;
   logic [31:0] mem [21];
   int          n_cmp = 0, n_bad = 0;

   instr_fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .jump_req(jump_req), .jump_index(jump_index),
      .branch_req(branch_req), .branch_base(branch_base), .branch_imm(branch_imm),
      .imem_instr(imem_instr), .imem_addr(imem_addr), .if_id_instr(if_id_instr),
      .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;
   assign imem_instr = (imem_addr[31:2] < 30'd21) ? mem[imem_addr[6:2]] : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int i = 0; i < 21; i++) mem[i] = 32'h1000_0000 + i;
      mem[0] = 32'h8C10_0000;
      #12;
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", {31'd0, if_id_valid}, 32'd0);
      check("rst_instr", if_id_instr, 32'h0);
      check("rst_pc4", if_id_pc4, 32'h0);
      check("rst_count", fetch_count, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      tick();
      rst = 1'b0;
      check("seq_addr0", imem_addr, 32'h0);
      tick();
      check("seq_addr4", imem_addr, 32'h4);
      check("seq_instr", if_id_instr, 32'h8C10_0000);
      check("seq_pc4", if_id_pc4, 32'h4);
      check("seq_valid", {31'd0, if_id_valid}, 32'd1);
      check("seq_count1", fetch_count, 32'd1);
      tick();
      check("seq_addr8", imem_addr, 32'h8);
      tick();
      check("seq_addr12", imem_addr, 32'hC);
      // stall at pc=12
      stall = 1'b1;
      tick(2);
      check("stall_addr", imem_addr, 32'hC);
      check("stall_instr", if_id_instr, mem[2]);
      check("stall_pc4", if_id_pc4, 32'hC);
      check("stall_count", fetch_count, 32'd3);
      stall = 1'b0;
      tick();
      check("unstall_addr", imem_addr, 32'h10);
      check("unstall_count", fetch_count, 32'd4);
      // branches
      branch_req = 1'b1; branch_base = 32'h20; branch_imm = 16'h0001;
      tick();
      check("br_fwd_addr", imem_addr, 32'h24);
      check("br_valid", {31'd0, if_id_valid}, 32'd0);
      check("br_instr", if_id_instr, 32'h0);
      check("br_count", fetch_count, 32'd4);
      branch_imm = 16'hFFFE;
      tick();
      check("br_back_addr", imem_addr, 32'h18);
      branch_req = 1'b0;
      tick(3);
      check("pre_jump_pc4", if_id_pc4, 32'h24);
      check("pre_jump_count", fetch_count, 32'd7);
      // jumps
      jump_req = 1'b1; jump_index = 26'd13;
      tick();
      check("jmp_addr", imem_addr, 32'h34);
      check("jmp_valid", {31'd0, if_id_valid}, 32'd0);
      check("jmp_pc4", if_id_pc4, 32'h0);
      check("jmp_count", fetch_count, 32'd7);
      branch_req = 1'b1; branch_base = 32'h100; branch_imm = 16'h0000; jump_index = 26'd5;
      tick();
      check("jmp_wins_addr", imem_addr, 32'h14);
      stall = 1'b1; jump_index = 26'd2;
      tick();
      check("stall_jmp_addr", imem_addr, 32'h14);
      stall = 1'b0; jump_req = 1'b0; branch_req = 1'b0;
      // end of program from a fresh start
      rst = 1'b1;
      #1;
      rst = 1'b0;
      check("rst2_addr", imem_addr, 32'h0);
      tick(21);
      check("eop_addr", imem_addr, 32'd84);
      check("eop_halted", {31'd0, halted}, 32'd1);
      check("eop_count", fetch_count, 32'd21);
      check("eop_last_instr", if_id_instr, mem[20]);
      check("eop_last_valid", {31'd0, if_id_valid}, 32'd1);
      tick();
      check("halt_addr", imem_addr, 32'd84);
      check("halt_valid", {31'd0, if_id_valid}, 32'd0);
      check("halt_instr", if_id_instr, 32'h0);
      tick();
      check("halt_valid2", {31'd0, if_id_valid}, 32'd0);
      check("halt_count", fetch_count, 32'd21);
      jump_req = 1'b1; jump_index = 26'd3;
      tick();
      jump_req = 1'b0;
      check("resume_addr", imem_addr, 32'hC);
      check("resume_halted", {31'd0, halted}, 32'd0);
      check("resume_count", fetch_count, 32'd21);
      tick(7);
      check("pre_arst_addr", imem_addr, 32'd40);
      check("pre_arst_count", fetch_count, 32'd28);
      // async reset between edges
      #2;
      rst = 1'b1;
      #1;
      check("arst_addr", imem_addr, 32'h0);
      check("arst_valid", {31'd0, if_id_valid}, 32'd0);
      check("arst_count", fetch_count, 32'd0);
      check("arst_instr", if_id_instr, 32'h0);
      #1;
      rst = 1'b0;
      tick();
      check("post_arst_addr", imem_addr, 32'h4);
      check("post_arst_instr", if_id_instr, 32'h8C10_0000);
      check("post_arst_count", fetch_count, 32'd1);
      tick();
      check("post_arst_addr8", imem_addr, 32'h8);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
